att_serial_rx: RTL and testbench

Serial-word receiver for the attenuator control link: deserializes the SI/CLK/LE frame driven by the AXI attenuator controller and presents the latched control word in the system clock domain. Used as the on-board model of the attenuator's serial input in loopback, and as the capture block that checks every programmed word against the AXI register value. Frame is LSB-first; the word is loaded on the rising edge of LE.

---
 rtl/att_serial_rx.sv | 160 ++++++++++++++++
 tb/tb_att_serial_rx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/att_serial_rx.sv
`timescale 1ns/1ps
// att_serial_rx: receives the attenuator SI/CLK/LE serial frame (LSB first)
// in the aclk domain, latches a correctly sized word on the rising edge of LE,
// and reports badly framed LE edges through a pulse and a saturating counter.
module att_serial_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             ser_clk,
  input  logic             ser_si,
  input  logic             ser_le,
  output logic [WIDTH-1:0] att_word,
  output logic             word_valid,
  output logic             frame_err,
  output logic [7:0]       err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [5:0] FULL_COUNT = 6'(WIDTH);
  localparam logic [5:0] MAX_COUNT  = 6'd63;
  localparam logic [7:0] MAX_ERRORS = 8'd255;

  // Synchronizer chains and the extra edge-detect copies. These flops are
  // deliberately not reset so that they keep tracking the pins during reset;
  // a level that is already high at reset release then produces no edge.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] si_sync;
  logic [SYNC_STAGES-1:0] le_sync;
  logic                   clk_d;
  logic                   le_d;

  logic clk_s;
  logic si_s;
  logic le_s;
  logic clk_rise;
  logic le_rise;
  logic le_fall;

  // Frame state and datapath registers with their next-state values.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [5:0]       cnt;
  logic [5:0]       cnt_next;
  logic [WIDTH-1:0] word_next;
  logic             valid_next;
  logic             err_next;
  logic [7:0]       err_cnt_next;

  // Values after a possible shift in this cycle; a simultaneous LE rise
  // judges the frame on these so the last bit is never lost.
  logic             shift_en;
  logic [WIDTH-1:0] post_sr;
  logic [5:0]       post_cnt;
  logic [5:0]       cnt_inc;

  // Clock all three pins through matching synchronizer depths so SI stays
  // aligned with the synchronized CLK, then keep one more copy for edges.
  always_ff @(posedge aclk) begin
    clk_sync <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
    si_sync  <= {si_sync[SYNC_STAGES-2:0], ser_si};
    le_sync  <= {le_sync[SYNC_STAGES-2:0], ser_le};
    clk_d    <= clk_sync[SYNC_STAGES-1];
    le_d     <= le_sync[SYNC_STAGES-1];
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign le_s     = le_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign le_rise  = le_s & ~le_d;
  assign le_fall  = ~le_s & le_d;

  assign cnt_inc  = (cnt == MAX_COUNT) ? cnt : cnt + 6'd1;
  assign shift_en = clk_rise && (state != HOLD);
  assign post_sr  = shift_en ? {si_s, sr[WIDTH-1:1]} : sr;
  assign post_cnt = shift_en ? ((state == IDLE) ? 6'd1 : cnt_inc) : cnt;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, shift/count and frame judgement for the current cycle.
  always_comb begin
    state_next   = state;
    sr_next      = sr;
    cnt_next     = cnt;
    word_next    = att_word;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    err_cnt_next = err_cnt;

    case (state)
      IDLE, SHIFT: begin
        sr_next  = post_sr;
        cnt_next = post_cnt;
        if (le_rise) begin
          state_next = HOLD;
          if (post_cnt == FULL_COUNT) begin
            word_next  = post_sr;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
            if (err_cnt != MAX_ERRORS) begin
              err_cnt_next = err_cnt + 8'd1;
            end
          end
        end else if (shift_en) begin
          state_next = SHIFT;
        end
      end
      HOLD: begin
        if (le_fall) begin
          state_next = IDLE;
          cnt_next   = 6'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sr         <= '0;
      cnt        <= 6'd0;
      att_word   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      sr         <= sr_next;
      cnt        <= cnt_next;
      att_word   <= word_next;
      word_valid <= valid_next;
      frame_err  <= err_next;
      err_cnt    <= err_cnt_next;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_att_serial_rx.sv
`timescale 1ns/1ps
// Directed bench for att_serial_rx: sends LSB-first frames at 10 MHz against
// a 100 MHz aclk and checks latched words, pulse counts and the error counter.
module tb_att_serial_rx;

  logic        aclk;
  logic        areset;
  logic        ser_clk;
  logic        ser_si;
  logic        ser_le;
  logic [15:0] att_word;
  logic        word_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int vectors;
  int miscompares;
  int valid_seen;
  int ferr_seen;
  int overlap_seen;

  att_serial_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .ser_clk    (ser_clk),
    .ser_si     (ser_si),
    .ser_le     (ser_le),
    .att_word   (att_word),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  // 100 MHz system clock.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count pulse cycles away from the active edge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (word_valid) valid_seen++;
      if (frame_err) ferr_seen++;
      if (word_valid && frame_err) overlap_seen++;
    end
  end

  // Shift nbits of data out LSB first, 100 ns per bit.
  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ser_si = data[i];
      #20;
      ser_clk = 1'b1;
      #50;
      ser_clk = 1'b0;
      #30;
    end
  endtask

  task automatic pulse_le();
    ser_le = 1'b1;
    #100;
    ser_le = 1'b0;
    #100;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits);
    send_bits(data, nbits);
    #40;
    pulse_le();
  endtask

  task automatic test_reset();
    areset  = 1'b1;
    ser_clk = 1'b0;
    ser_si  = 1'b0;
    ser_le  = 1'b0;
    repeat (6) @(negedge aclk);
    vectors++;
    if (att_word !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_att_word got %h expected %h", att_word, 16'h0000);
    end
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_word_valid got %b expected 0", word_valid);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_err got %b expected 0", frame_err);
    end
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_err_cnt got %0d expected 0", err_cnt);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy got %b expected 0", busy);
    end
    areset = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_single_frame();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    send_bits(32'h0378, 4);
    @(negedge aclk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_busy_mid got %b expected 1", busy);
    end
    send_bits(32'h0378 >> 4, 12);
    #40;
    pulse_le();
    @(negedge aclk);
    vectors++;
    if (att_word !== 16'h0378) begin
      miscompares++;
      $display("[TB] FAIL single_word got %h expected %h", att_word, 16'h0378);
    end
    vectors++;
    if (valid_seen - v0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL single_valid_pulses got %0d expected 1", valid_seen - v0);
    end
    vectors++;
    if (ferr_seen - f0 !== 0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL single_errors got pulses %0d cnt %0d expected 0 0", ferr_seen - f0, err_cnt);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_busy_after got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    send_frame(32'h0378, 16);
    @(negedge aclk);
    vectors++;
    if (att_word !== 16'h0378) begin
      miscompares++;
      $display("[TB] FAIL b2b_first got %h expected %h", att_word, 16'h0378);
    end
    send_frame(32'h005A, 16);
    @(negedge aclk);
    vectors++;
    if (att_word !== 16'h005A) begin
      miscompares++;
      $display("[TB] FAIL b2b_second got %h expected %h", att_word, 16'h005A);
    end
    vectors++;
    if (valid_seen - v0 !== 2 || ferr_seen - f0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_pulses got valid %0d err %0d expected 2 0", valid_seen - v0, ferr_seen - f0);
    end
  endtask

  task automatic test_bad_frames();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    send_frame(32'h0000_1234, 15);
    send_frame(32'h0001_5678, 17);
    pulse_le();
    @(negedge aclk);
    vectors++;
    if (ferr_seen - f0 !== 3) begin
      miscompares++;
      $display("[TB] FAIL bad_err_pulses got %0d expected 3", ferr_seen - f0);
    end
    vectors++;
    if (err_cnt !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL bad_err_cnt got %0d expected 3", err_cnt);
    end
    vectors++;
    if (att_word !== 16'h005A || valid_seen - v0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL bad_word_kept got %h valid %0d expected 005a 0", att_word, valid_seen - v0);
    end
  endtask

  task automatic test_hold_clocks();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    send_bits(32'h1111, 16);
    #40;
    ser_le = 1'b1;
    #100;
    send_bits(32'h0000_0007, 3);
    @(negedge aclk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_busy got %b expected 0", busy);
    end
    #40;
    ser_le = 1'b0;
    #100;
    send_frame(32'hF85A, 16);
    @(negedge aclk);
    vectors++;
    if (att_word !== 16'hF85A) begin
      miscompares++;
      $display("[TB] FAIL hold_word got %h expected %h", att_word, 16'hF85A);
    end
    vectors++;
    if (valid_seen - v0 !== 2 || ferr_seen - f0 !== 0 || err_cnt !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL hold_pulses got valid %0d err %0d cnt %0d expected 2 0 3", valid_seen - v0, ferr_seen - f0, err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    send_bits(32'h00FF, 8);
    @(negedge aclk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_busy_before got %b expected 1", busy);
    end
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    vectors++;
    if (busy !== 1'b0 || att_word !== 16'h0000 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_in_reset got busy %b word %h cnt %0d expected 0 0000 0", busy, att_word, err_cnt);
    end
    areset = 1'b0;
    repeat (4) @(negedge aclk);
    v0 = valid_seen;
    f0 = ferr_seen;
    send_frame(32'h1234, 16);
    @(negedge aclk);
    vectors++;
    if (att_word !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL midrst_word got %h expected %h", att_word, 16'h1234);
    end
    vectors++;
    if (valid_seen - v0 !== 1 || ferr_seen - f0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL midrst_pulses got valid %0d err %0d expected 1 0", valid_seen - v0, ferr_seen - f0);
    end
  endtask

  task automatic test_saturation();
    int v0, f0;
    f0 = ferr_seen;
    for (int i = 0; i < 256; i++) begin
      pulse_le();
    end
    @(negedge aclk);
    vectors++;
    if (err_cnt !== 8'd255) begin
      miscompares++;
      $display("[TB] FAIL sat_err_cnt got %0d expected 255", err_cnt);
    end
    vectors++;
    if (ferr_seen - f0 !== 256) begin
      miscompares++;
      $display("[TB] FAIL sat_err_pulses got %0d expected 256", ferr_seen - f0);
    end
    v0 = valid_seen;
    send_frame(32'hABCD, 16);
    @(negedge aclk);
    vectors++;
    if (att_word !== 16'hABCD || valid_seen - v0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL sat_word got %h valid %0d expected abcd 1", att_word, valid_seen - v0);
    end
    vectors++;
    if (err_cnt !== 8'd255) begin
      miscompares++;
      $display("[TB] FAIL sat_err_cnt_after got %0d expected 255", err_cnt);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    valid_seen   = 0;
    ferr_seen    = 0;
    overlap_seen = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_frames();
    test_hold_clocks();
    test_reset_mid_frame();
    test_saturation();
    vectors++;
    if (overlap_seen !== 0) begin
      miscompares++;
      $display("[TB] FAIL pulse_exclusive got %0d overlapping cycles expected 0", overlap_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
